// File: rtl/tick_ctrl_pkg.sv
// Shared FSM encodings and prescaler sizing for tick_ctrl.
// Optional debounce filter in btn_filter is enabled by defining TICK_CTRL_DEBOUNCE_EN.
package tick_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE
    } tick_state_e;

    // ceil(log2(div)), never narrower than one bit.
    function automatic int unsigned pre_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_ctrl_if.sv
// Button inputs, timer control outputs and FSM state visibility for tick_ctrl.
interface tick_ctrl_if;

    // No valid/ready handshake here: buttons are raw levels, e and clr are
    // single-cycle pulses, running is a level, state_dbg mirrors the FSM register.
    logic       btn_start;
    logic       btn_stop;
    logic       e;
    logic       running;
    logic       clr;
    logic [1:0] state_dbg;

    modport master (
        output btn_start, btn_stop,
        input  e, running, clr, state_dbg
    );

    modport slave (
        input  btn_start, btn_stop,
        output e, running, clr, state_dbg
    );

endinterface

// File: rtl/tick_ctrl_btn_filter.sv
// Per-button synchronizer, optional debounce filter and rising-edge press detector.
// Filter present only when TICK_CTRL_DEBOUNCE_EN is defined.
module btn_filter #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic res,
    input  logic btn_raw,
    output logic press
);

    logic [1:0] sync_q, sync_d;
    logic [1:0] prime_q, prime_d;
    logic       prev_q, prev_d;
    logic       arm_q, arm_d;
    logic       level;

`ifdef TICK_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Any sample that agrees with the current output restarts the stability count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    logic db_unused;
    assign db_unused = (DB_CYCLES > 0);
    assign level     = sync_q[1];
`endif

    // Presses are only armed once the primed synchronizer has seen the button
    // released, so a button held through reset never counts as a press.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        prime_d = {prime_q[0], 1'b1};
        prev_d  = level;
        arm_d   = arm_q | (prime_q[1] & ~sync_q[1]);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sync_q  <= '0;
            prime_q <= '0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
        end
    end

    assign press = level & ~prev_q & arm_q;

endmodule

// File: rtl/tick_ctrl.sv
// Start/pause/clear controller producing a prescaled count-enable pulse.
// Button debounce filtering is enabled by defining TICK_CTRL_DEBOUNCE_EN.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int DIV       = 5,
    parameter int DB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        res,
    tick_ctrl_if.slave  bus
);

    localparam int              PW       = pre_width(DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);

    logic          start_p;
    logic          stop_p;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          clr_q, clr_d;

    btn_filter #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clk     (clk),
        .res     (res),
        .btn_raw (bus.btn_start),
        .press   (start_p)
    );

    btn_filter #(.DB_CYCLES(DB_CYCLES)) u_stop (
        .clk     (clk),
        .res     (res),
        .btn_raw (bus.btn_stop),
        .press   (stop_p)
    );

    // Stop is tested first in every state so a simultaneous start is dropped.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p && !stop_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_p) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop_p) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pre_d = pre_q;
        if (state_q == ST_RUN) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
        if (state_d == ST_IDLE) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            clr_q   <= clr_d;
        end
    end

    assign bus.e         = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign bus.running   = (state_q == ST_RUN);
    assign bus.clr       = clr_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl with DIV=4, DB_CYCLES=3; checks on the falling edge.
module tb_tick_ctrl;
    import tick_ctrl_pkg::*;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic clk = 1'b0;
    logic res;
    int   n_vec = 0;
    int   n_err = 0;

    tick_ctrl_if bus();

    tick_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then compare all outputs against the hand-derived state.
    task automatic step(input string tag, input logic [1:0] st, input logic e_exp, input logic clr_exp);
        @(negedge clk);
        check({tag, ".state"},   32'(bus.state_dbg), 32'(st));
        check({tag, ".running"}, 32'(bus.running),   32'(st == ST_RUN));
        check({tag, ".e"},       32'(bus.e),         32'(e_exp));
        check({tag, ".clr"},     32'(bus.clr),       32'(clr_exp));
    endtask

    initial begin
        res           = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("rst%0d", i), ST_IDLE, 1'b0, 1'b0);

`ifdef TICK_CTRL_DEBOUNCE_EN
        // 2-cycle glitch on start is rejected
        bus.btn_start = 1'b1;
        step("g_0", ST_IDLE, 1'b0, 1'b0);
        step("g_1", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        for (int i = 0; i < 8; i++) step($sformatf("g_idle%0d", i), ST_IDLE, 1'b0, 1'b0);

        // 5-cycle press reaches RUN after 3 sync/edge + 3 filter edges
        bus.btn_start = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("f_wait%0d", i), ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        step("f_run1", ST_RUN, 1'b0, 1'b0);

        // stop held 50+ cycles gives a single press: PAUSE, never IDLE
        bus.btn_stop = 1'b1;
        for (int k = 2; k <= 6; k++) step($sformatf("f_run%0d", k), ST_RUN, 1'(k == 4), 1'b0);
        for (int i = 0; i < 50; i++) step($sformatf("f_hold%0d", i), ST_PAUSE, 1'b0, 1'b0);
        bus.btn_stop = 1'b0;
        for (int i = 0; i < 6; i++) step($sformatf("f_rel%0d", i), ST_PAUSE, 1'b0, 1'b0);
`else
        // start: RUN three edges later, e on RUN cycles 4, 8, 12
        bus.btn_start = 1'b1;
        step("a_sync1", ST_IDLE, 1'b0, 1'b0);
        step("a_sync2", ST_IDLE, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) step($sformatf("a_run%0d", k), ST_RUN, 1'(k % 4 == 0), 1'b0);
        bus.btn_start = 1'b0;

        // stop lands while prescaler=2; resume fires e in the first RUN cycle
        step("b_pre0", ST_RUN, 1'b0, 1'b0);
        bus.btn_stop = 1'b1;
        step("b_pre1", ST_RUN, 1'b0, 1'b0);
        step("b_pre2", ST_RUN, 1'b0, 1'b0);
        bus.btn_stop = 1'b0;
        for (int i = 0; i < 11; i++) step($sformatf("b_pause%0d", i), ST_PAUSE, 1'b0, 1'b0);
        bus.btn_start = 1'b1;
        step("b_res1", ST_PAUSE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        step("b_res2", ST_PAUSE, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) step($sformatf("b_run%0d", k), ST_RUN, 1'(k == 1 || k == 5), 1'b0);

        // pause, then stop from PAUSE: one clr pulse, then a full fresh period
        bus.btn_stop = 1'b1;
        step("c_run6", ST_RUN, 1'b0, 1'b0);
        bus.btn_stop = 1'b0;
        step("c_run7", ST_RUN, 1'b0, 1'b0);
        step("c_pause", ST_PAUSE, 1'b0, 1'b0);
        bus.btn_stop = 1'b1;
        step("c_p1", ST_PAUSE, 1'b0, 1'b0);
        bus.btn_stop = 1'b0;
        step("c_p2", ST_PAUSE, 1'b0, 1'b0);
        step("c_clr", ST_IDLE, 1'b0, 1'b1);
        step("c_idle", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b1;
        step("c_s1", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        step("c_s2", ST_IDLE, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) step($sformatf("c_run%0d", k), ST_RUN, 1'(k == 4), 1'b0);

        // simultaneous start+stop: RUN -> PAUSE, IDLE stays IDLE
        bus.btn_start = 1'b1;
        bus.btn_stop  = 1'b1;
        step("d_run5", ST_RUN, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        step("d_run6", ST_RUN, 1'b0, 1'b0);
        step("d_pause", ST_PAUSE, 1'b0, 1'b0);
        bus.btn_stop = 1'b1;
        step("d_p1", ST_PAUSE, 1'b0, 1'b0);
        bus.btn_stop = 1'b0;
        step("d_p2", ST_PAUSE, 1'b0, 1'b0);
        step("d_clr", ST_IDLE, 1'b0, 1'b1);
        step("d_idle", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b1;
        bus.btn_stop  = 1'b1;
        step("d_both1", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        for (int i = 2; i <= 4; i++) step($sformatf("d_both%0d", i), ST_IDLE, 1'b0, 1'b0);

        // reset mid-RUN with start held: IDLE, no e/clr, no RUN until re-pressed
        bus.btn_start = 1'b1;
        step("e_s1", ST_IDLE, 1'b0, 1'b0);
        step("e_s2", ST_IDLE, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step($sformatf("e_run%0d", k), ST_RUN, 1'b0, 1'b0);
        res = 1'b1;
        step("e_rst", ST_IDLE, 1'b0, 1'b0);
        res = 1'b0;
        for (int i = 0; i < 6; i++) step($sformatf("e_held%0d", i), ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("e_rel%0d", i), ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b1;
        step("e_p1", ST_IDLE, 1'b0, 1'b0);
        bus.btn_start = 1'b0;
        step("e_p2", ST_IDLE, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) step($sformatf("e_again%0d", k), ST_RUN, 1'(k == 4), 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
